// File: rtl/mux_4x1_pkg.sv
// Shared select type and code points for the registered 4:1 word mux.
// Used by the top and by anything that drives the select pair.
package mux_4x1_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_A = 2'b00;
    localparam sel_t SEL_B = 2'b01;
    localparam sel_t SEL_C = 2'b10;
    localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/mux_4x1_if.sv
// Data/select bundle for mux_4x1: master drives words and selects, slave returns out.
// No handshake; the slave samples every rising clk edge.
interface mux_4x1_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             s0;
    logic             s1;
    logic [WIDTH-1:0] out;

    modport master (
        output a, b, c, d, s0, s1,
        input  out
    );

    modport slave (
        input  a, b, c, d, s0, s1,
        output out
    );
endinterface

// File: rtl/mux_2x1.sv
// WIDTH-bit 2:1 word mux, purely combinational (0 cycles).
// Backpressure: none.
module mux_2x1 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? in1 : in0;

endmodule

// File: rtl/mux_4x1.sv
// Registered 4:1 word mux ({s1,s0}: 00 a, 01 b, 10 c, 11 d); latency 1 cycle.
// Backpressure: none, loads every cycle; rst_n clears out asynchronously.
module mux_4x1
    import mux_4x1_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    mux_4x1_if.slave   bus
);

    sel_t             sel;
    logic [WIDTH-1:0] ab_dat;
    logic [WIDTH-1:0] cd_dat;
    logic [WIDTH-1:0] mux_dat;
    logic [WIDTH-1:0] out_q;

    assign sel = {bus.s1, bus.s0};

    // s0 picks within each pair, s1 picks between the pairs.
    mux_2x1 #(.WIDTH(WIDTH)) u_ab (
        .in0 (bus.a),
        .in1 (bus.b),
        .sel (sel[0]),
        .y   (ab_dat)
    );

    mux_2x1 #(.WIDTH(WIDTH)) u_cd (
        .in0 (bus.c),
        .in1 (bus.d),
        .sel (sel[0]),
        .y   (cd_dat)
    );

    mux_2x1 #(.WIDTH(WIDTH)) u_out (
        .in0 (ab_dat),
        .in1 (cd_dat),
        .sel (sel[1]),
        .y   (mux_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= mux_dat;
        end
    end

    assign bus.out = out_q;

endmodule

// File: tb/tb_mux_4x1.sv
// Bench for mux_4x1 at WIDTH=4 and WIDTH=8: directed scenarios plus randomized traffic.
module tb_mux_4x1;
    import mux_4x1_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   passed;

    mux_4x1_if #(.WIDTH(4)) if4 ();
    mux_4x1_if #(.WIDTH(8)) if8 ();

    mux_4x1 #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    mux_4x1 #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the selected word is simply the {s1,s0}-th entry of {a,b,c,d}.
    function automatic logic [3:0] pick4(logic [3:0] a, logic [3:0] b, logic [3:0] c,
                                         logic [3:0] d, logic s1, logic s0);
        logic [3:0] w [4];
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        return w[{s1, s0}];
    endfunction

    function automatic logic [7:0] pick8(logic [7:0] a, logic [7:0] b, logic [7:0] c,
                                         logic [7:0] d, logic s1, logic s0);
        logic [7:0] w [4];
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        return w[{s1, s0}];
    endfunction

    task automatic set4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input sel_t sel);
        if4.a = a; if4.b = b; if4.c = c; if4.d = d;
        if4.s1 = sel[1]; if4.s0 = sel[0];
    endtask

    task automatic set8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] d, input sel_t sel);
        if8.a = a; if8.b = b; if8.c = c; if8.d = d;
        if8.s1 = sel[1]; if8.s0 = sel[0];
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set4(4'b0010, 4'b1001, 4'b1110, 4'b0011, SEL_B);
        set8(8'hA5, 8'h3C, 8'hF0, 8'h0F, SEL_B);
        #1;
        checks++;
        if (if4.out !== 4'b0000) $display("FAIL reset_immediate out=%b expected=%b", if4.out, 4'b0000);
        else passed++;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (if4.out !== 4'b0000 || if8.out !== 8'h00)
            $display("FAIL reset_held out4=%b out8=%h expected=0", if4.out, if8.out);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        set4(4'b0010, 4'b1001, 4'b1110, 4'b0011, SEL_C);
        @(posedge clk);
        #1;
        checks++;
        if (if4.out !== 4'b1110) $display("FAIL reset_release out=%b expected=%b", if4.out, 4'b1110);
        else passed++;
    endtask

    task automatic test_sweep4;
        sel_t       sels [4] = '{SEL_C, SEL_D, SEL_A, SEL_B};
        logic [3:0] exps [4] = '{4'b1110, 4'b0011, 4'b0010, 4'b1001};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set4(4'b0010, 4'b1001, 4'b1110, 4'b0011, sels[i]);
            @(posedge clk);
            #1;
            checks++;
            if (if4.out !== exps[i])
                $display("FAIL sweep4 sel=%b out=%b expected=%b", sels[i], if4.out, exps[i]);
            else passed++;
        end
    endtask

    task automatic test_hold;
        @(negedge clk);
        set4(4'b0010, 4'b1001, 4'b1110, 4'b0011, SEL_A);
        @(posedge clk);
        #2;
        set4(4'b0010, 4'b1001, 4'b1110, 4'b0011, SEL_D);
        #1;
        checks++;
        if (if4.out !== 4'b0010) $display("FAIL hold_midcycle out=%b expected=%b", if4.out, 4'b0010);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (if4.out !== 4'b0011) $display("FAIL hold_next_edge out=%b expected=%b", if4.out, 4'b0011);
        else passed++;
    endtask

    task automatic test_data_tracking;
        @(negedge clk);
        set4(4'b0010, 4'b1001, 4'b1110, 4'b0011, SEL_B);
        @(posedge clk);
        #2;
        if4.b = 4'b0110;
        #1;
        checks++;
        if (if4.out !== 4'b1001) $display("FAIL track_hold out=%b expected=%b", if4.out, 4'b1001);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (if4.out !== 4'b0110) $display("FAIL track_b out=%b expected=%b", if4.out, 4'b0110);
        else passed++;
        if4.a = 4'b1111; if4.c = 4'b0000; if4.d = 4'b0101;
        @(posedge clk);
        #1;
        checks++;
        if (if4.out !== 4'b0110) $display("FAIL track_others out=%b expected=%b", if4.out, 4'b0110);
        else passed++;
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        set4(4'b0010, 4'b1001, 4'b1110, 4'b0011, SEL_C);
        @(posedge clk);
        #1;
        checks++;
        if (if4.out !== 4'b1110) $display("FAIL areset_pre out=%b expected=%b", if4.out, 4'b1110);
        else passed++;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (if4.out !== 4'b0000) $display("FAIL areset_clear out=%b expected=%b", if4.out, 4'b0000);
        else passed++;
        #1;
        rst_n = 1'b1;
        checks++;
        if (if4.out !== 4'b0000) $display("FAIL areset_no_retain out=%b expected=%b", if4.out, 4'b0000);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (if4.out !== 4'b1110) $display("FAIL areset_restore out=%b expected=%b", if4.out, 4'b1110);
        else passed++;
    endtask

    task automatic test_width8;
        sel_t       sels [4] = '{SEL_A, SEL_B, SEL_C, SEL_D};
        logic [7:0] exps [4] = '{8'hA5, 8'h3C, 8'hF0, 8'h0F};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set8(8'hA5, 8'h3C, 8'hF0, 8'h0F, sels[i]);
            @(posedge clk);
            #1;
            checks++;
            if (if8.out !== exps[i])
                $display("FAIL width8 sel=%b out=%h expected=%h", sels[i], if8.out, exps[i]);
            else passed++;
        end
    endtask

    task automatic test_random;
        logic [3:0] exp4;
        logic [7:0] exp8;
        int         errs;
        errs = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            set4(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 2'($urandom));
            set8(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom));
            exp4 = pick4(if4.a, if4.b, if4.c, if4.d, if4.s1, if4.s0);
            exp8 = pick8(if8.a, if8.b, if8.c, if8.d, if8.s1, if8.s0);
            @(posedge clk);
            #1;
            checks++;
            if (if4.out !== exp4 || if8.out !== exp8) begin
                if (errs < 10)
                    $display("FAIL random_load iter=%0d out4=%h exp4=%h out8=%h exp8=%h",
                             i, if4.out, exp4, if8.out, exp8);
                errs++;
            end else passed++;
            #1;
            set4(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 2'($urandom));
            set8(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom));
            #1;
            checks++;
            if (if4.out !== exp4 || if8.out !== exp8) begin
                if (errs < 10)
                    $display("FAIL random_hold iter=%0d out4=%h exp4=%h out8=%h exp8=%h",
                             i, if4.out, exp4, if8.out, exp8);
                errs++;
            end else passed++;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_sweep4();
        test_hold();
        test_data_tracking();
        test_async_reset();
        test_width8();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
